// File: rtl/lcd_line_buffer.sv
// lcd_line_buffer: captures the LCD pixel stream into two ping-pong line banks.
// Each complete line is replayed on a valid/ready stream tagged with x/y and
// start/end markers. Lines that are short, overlong, or find no free bank are
// discarded and counted.
module lcd_line_buffer #(
    parameter int LINE_WIDTH = 160,
    parameter int X_BITS     = 8,
    parameter int DROP_BITS  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           pixel_data,
    input  logic                 pixel_latch,
    input  logic                 hsync,
    input  logic                 vsync,
    output logic [1:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [X_BITS-1:0]    out_x,
    output logic [X_BITS-1:0]    out_y,
    output logic                 out_sol,
    output logic                 out_eol,
    output logic                 out_sof,
    output logic                 frame_sync,
    output logic                 in_sync,
    output logic [DROP_BITS-1:0] drop_count
);
    // One extra bit so the write counter can hold LINE_WIDTH itself.
    localparam int CW = X_BITS + 1;
    localparam logic [CW-1:0]     LW     = CW'(LINE_WIDTH);
    localparam logic [X_BITS-1:0] LAST_X = X_BITS'(LINE_WIDTH - 1);

    typedef enum logic { WAIT_VSYNC, CAPTURE } wr_state_t;
    typedef enum logic { IDLE, STREAM }        rd_state_t;

    logic [1:0] mem [2][LINE_WIDTH];

    logic                        hsync_q, vsync_q;
    logic                        hsync_edge, vsync_edge;
    wr_state_t                   wr_state;
    logic                        wr_bank;
    logic [CW-1:0]               wr_x;
    logic [X_BITS-1:0]           wr_y;
    logic                        overlong;
    logic                        blocked;
    logic [1:0]                  bank_full;
    logic [1:0][X_BITS-1:0]      bank_y;
    rd_state_t                   rd_state;
    logic                        rd_bank;

    logic                        rd_free;
    logic                        wr_bank_free;
    logic                        pix_in_range;
    logic                        store;
    logic [CW-1:0]               x_next;
    logic                        long_next;
    logic                        blocked_next;
    logic                        line_good;
    logic [X_BITS-1:0]           rd_x_next;

    // Edge detect, bank availability and end-of-line verdict for this cycle.
    always_comb begin
        hsync_edge   = hsync & ~hsync_q;
        vsync_edge   = vsync & ~vsync_q;
        rd_free      = (rd_state == STREAM) && out_valid && out_ready && out_eol;
        // A bank released by the reader this very cycle is already usable.
        wr_bank_free = !bank_full[wr_bank] || (rd_free && (rd_bank == wr_bank));
        pix_in_range = pixel_latch && (wr_x < LW);
        store        = (wr_state == CAPTURE) && pix_in_range && wr_bank_free;
        x_next       = pix_in_range ? wr_x + CW'(1) : wr_x;
        long_next    = overlong || (pixel_latch && (wr_x >= LW));
        // Any pixel that arrived while the bank was still held spoils the line.
        blocked_next = blocked || (pix_in_range && !wr_bank_free);
        line_good    = (x_next == LW) && !long_next && !blocked_next && wr_bank_free;
        rd_x_next    = out_x + X_BITS'(1);
    end

    // Pixel storage; contents need no reset because bank_full gates every read.
    always_ff @(posedge clock) begin
        if (store) mem[wr_bank][wr_x[X_BITS-1:0]] <= pixel_data;
    end

    // Writer: sync tracking, line bookkeeping, bank ownership and drop count.
    always_ff @(posedge clock) begin
        if (reset) begin
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            frame_sync <= 1'b0;
            in_sync    <= 1'b0;
            drop_count <= '0;
            wr_state   <= WAIT_VSYNC;
            wr_bank    <= 1'b0;
            wr_x       <= '0;
            wr_y       <= '0;
            overlong   <= 1'b0;
            blocked    <= 1'b0;
            bank_full  <= '0;
            bank_y     <= '0;
        end else begin
            hsync_q    <= hsync;
            vsync_q    <= vsync;
            frame_sync <= vsync_edge;
            if (rd_free) bank_full[rd_bank] <= 1'b0;
            case (wr_state)
                WAIT_VSYNC: begin
                    if (vsync_edge) begin
                        wr_state <= CAPTURE;
                        in_sync  <= 1'b1;
                        wr_x     <= '0;
                        wr_y     <= '0;
                        overlong <= 1'b0;
                        blocked  <= 1'b0;
                    end
                end
                CAPTURE: begin
                    wr_x     <= x_next;
                    overlong <= long_next;
                    blocked  <= blocked_next;
                    if (hsync_edge) begin
                        if (line_good) begin
                            bank_full[wr_bank] <= 1'b1;
                            bank_y[wr_bank]    <= wr_y;
                            wr_bank            <= ~wr_bank;
                        end else if (drop_count != '1) begin
                            drop_count <= drop_count + DROP_BITS'(1);
                        end
                        wr_x     <= '0;
                        overlong <= 1'b0;
                        blocked  <= 1'b0;
                        if (wr_y != '1) wr_y <= wr_y + X_BITS'(1);
                    end
                    // Frame start wins over the hsync row advance; partial line is lost silently.
                    if (vsync_edge) begin
                        wr_x     <= '0;
                        wr_y     <= '0;
                        overlong <= 1'b0;
                        blocked  <= 1'b0;
                    end
                end
                default: wr_state <= WAIT_VSYNC;
            endcase
        end
    end

    // Reader: replays full banks in fill order with registered stream outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state  <= IDLE;
            rd_bank   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_sol   <= 1'b0;
            out_eol   <= 1'b0;
            out_sof   <= 1'b0;
        end else begin
            case (rd_state)
                IDLE: begin
                    if (bank_full[rd_bank]) begin
                        rd_state  <= STREAM;
                        out_valid <= 1'b1;
                        out_x     <= '0;
                        out_data  <= mem[rd_bank][0];
                        out_y     <= bank_y[rd_bank];
                        out_sol   <= 1'b1;
                        out_eol   <= (LINE_WIDTH == 1);
                        out_sof   <= (bank_y[rd_bank] == '0);
                    end
                end
                STREAM: begin
                    if (out_valid && out_ready) begin
                        if (out_eol) begin
                            rd_state  <= IDLE;
                            rd_bank   <= ~rd_bank;
                            out_valid <= 1'b0;
                            out_sol   <= 1'b0;
                            out_eol   <= 1'b0;
                            out_sof   <= 1'b0;
                        end else begin
                            out_x    <= rd_x_next;
                            out_data <= mem[rd_bank][rd_x_next];
                            out_sol  <= 1'b0;
                            out_sof  <= 1'b0;
                            out_eol  <= (rd_x_next == LAST_X);
                        end
                    end
                end
                default: rd_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_line_buffer.sv
// Directed bench for lcd_line_buffer: inputs change and outputs are sampled on
// the falling clock edge.
module tb_lcd_line_buffer;
    localparam int LW = 160;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] pixel_data = '0;
    logic       pixel_latch = 1'b0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic       out_ready = 1'b0;
    logic [1:0] out_data;
    logic       out_valid;
    logic [7:0] out_x, out_y;
    logic       out_sol, out_eol, out_sof;
    logic       frame_sync, in_sync;
    logic [7:0] drop_count;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    lcd_line_buffer #(.LINE_WIDTH(LW), .X_BITS(8), .DROP_BITS(8)) dut (
        .clock(clock), .reset(reset),
        .pixel_data(pixel_data), .pixel_latch(pixel_latch),
        .hsync(hsync), .vsync(vsync),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y),
        .out_sol(out_sol), .out_eol(out_eol), .out_sof(out_sof),
        .frame_sync(frame_sync), .in_sync(in_sync), .drop_count(drop_count)
    );

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        pixel_latch = 1'b0;
        hsync = 1'b0;
        vsync = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic pulse_vsync;
        vsync = 1'b1;
        tick;
        checks++;
        if (frame_sync !== 1'b1) $display("FAIL frame_sync_pulse: got %b need 1", frame_sync);
        else passed++;
        checks++;
        if (in_sync !== 1'b1) $display("FAIL in_sync_set: got %b need 1", in_sync);
        else passed++;
        vsync = 1'b0;
        tick;
        checks++;
        if (frame_sync !== 1'b0) $display("FAIL frame_sync_end: got %b need 0", frame_sync);
        else passed++;
    endtask

    // n pixels with data = x%4, then an hsync edge (merged onto the last pixel if merge).
    // Returns at the falling edge just after the hsync-edge cycle.
    task automatic send_line(input int n, input bit merge);
        for (int i = 0; i < n; i++) begin
            pixel_latch = 1'b1;
            pixel_data  = 2'(i % 4);
            hsync       = merge && (i == n - 1);
            tick;
        end
        if (!merge || n == 0) begin
            pixel_latch = 1'b0;
            hsync = 1'b1;
            tick;
        end
        pixel_latch = 1'b0;
        hsync = 1'b0;
    endtask

    // Drains one line, checking every accepted beat and that stalled outputs hold.
    task automatic collect_line(input logic [7:0] exp_y, input bit toggle);
        int beats = 0;
        bit stalled = 1'b0;
        logic [20:0] held = '0;
        logic [20:0] now_v, exp_v;
        for (int cyc = 0; cyc < 2000 && beats < LW; cyc++) begin
            now_v = {out_data, out_x, out_y, out_sol, out_eol, out_sof};
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || now_v !== held)
                    $display("FAIL stall_hold y=%0d: got valid=%b %h need valid=1 %h", exp_y, out_valid, now_v, held);
                else passed++;
            end
            out_ready = toggle ? cyc[0] : 1'b1;
            stalled = 1'b0;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    exp_v = {2'(beats % 4), 8'(beats), exp_y, beats == 0, beats == LW - 1,
                             (beats == 0) && (exp_y == 8'd0)};
                    checks++;
                    if (now_v !== exp_v)
                        $display("FAIL beat y=%0d x=%0d: got %h need %h", exp_y, beats, now_v, exp_v);
                    else passed++;
                    beats++;
                end else begin
                    stalled = 1'b1;
                    held = now_v;
                end
            end
            tick;
        end
        checks++;
        if (beats != LW) $display("FAIL beat_count y=%0d: got %0d need %0d", exp_y, beats, LW);
        else passed++;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({out_valid, out_data, out_x, out_y, out_sol, out_eol, out_sof} !== 21'd0)
            $display("FAIL reset_stream: got %b/%h/%h/%h need all zero", out_valid, out_data, out_x, out_y);
        else passed++;
        checks++;
        if ({frame_sync, in_sync, drop_count} !== 10'd0)
            $display("FAIL reset_status: got fs=%b sync=%b drop=%0d need 0", frame_sync, in_sync, drop_count);
        else passed++;
    endtask

    task automatic test_single_line;
        do_reset;
        out_ready = 1'b1;
        pulse_vsync;
        send_line(LW, 1'b0);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL latency_early: got valid=%b need 0", out_valid);
        else passed++;
        tick;
        checks++;
        if (out_valid !== 1'b1) $display("FAIL latency_2cyc: got valid=%b need 1", out_valid);
        else passed++;
        collect_line(8'd0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL after_eol_idle: got valid=%b need 0", out_valid);
        else passed++;
        checks++;
        if (drop_count !== 8'd0) $display("FAIL single_drop: got %0d need 0", drop_count);
        else passed++;
    endtask

    task automatic test_backpressure;
        do_reset;
        out_ready = 1'b0;
        pulse_vsync;
        send_line(LW, 1'b0);
        tick;
        tick;
        collect_line(8'd0, 1'b1);
    endtask

    task automatic test_overflow;
        do_reset;
        out_ready = 1'b0;
        pulse_vsync;
        send_line(LW, 1'b0);
        send_line(LW, 1'b0);
        send_line(LW, 1'b0);
        tick;
        checks++;
        if (drop_count !== 8'd1) $display("FAIL overflow_drop: got %0d need 1", drop_count);
        else passed++;
        checks++;
        if (out_valid !== 1'b1 || out_y !== 8'd0 || out_x !== 8'd0)
            $display("FAIL overflow_head: got valid=%b y=%0d x=%0d need 1/0/0", out_valid, out_y, out_x);
        else passed++;
        collect_line(8'd0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL gap_idle: got valid=%b need 0", out_valid);
        else passed++;
        tick;
        checks++;
        if (out_valid !== 1'b1) $display("FAIL gap_resume: got valid=%b need 1", out_valid);
        else passed++;
        collect_line(8'd1, 1'b0);
        repeat (3) tick;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL third_line_gone: got valid=%b need 0", out_valid);
        else passed++;
    endtask

    task automatic test_bad_lengths;
        do_reset;
        out_ready = 1'b1;
        pulse_vsync;
        send_line(100, 1'b0);
        checks++;
        if (drop_count !== 8'd1) $display("FAIL short_drop: got %0d need 1", drop_count);
        else passed++;
        send_line(LW, 1'b0);
        tick;
        collect_line(8'd1, 1'b0);
        send_line(170, 1'b0);
        checks++;
        if (drop_count !== 8'd2) $display("FAIL long_drop: got %0d need 2", drop_count);
        else passed++;
        repeat (3) tick;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL long_no_output: got valid=%b need 0", out_valid);
        else passed++;
    endtask

    task automatic test_no_vsync;
        do_reset;
        out_ready = 1'b1;
        send_line(LW, 1'b0);
        repeat (4) tick;
        checks++;
        if ({out_valid, in_sync, drop_count} !== 10'd0)
            $display("FAIL pre_vsync: got valid=%b sync=%b drop=%0d need 0/0/0", out_valid, in_sync, drop_count);
        else passed++;
    endtask

    task automatic test_reset_mid_stream;
        int beats = 0;
        do_reset;
        out_ready = 1'b1;
        pulse_vsync;
        send_line(50, 1'b0);
        send_line(LW, 1'b0);
        tick;
        for (int cyc = 0; cyc < 400 && beats < 80; cyc++) begin
            if (out_valid === 1'b1) beats++;
            tick;
        end
        checks++;
        if (out_x !== 8'd80 || drop_count !== 8'd1)
            $display("FAIL pre_reset_state: got x=%0d drop=%0d need 80/1", out_x, drop_count);
        else passed++;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++;
        if ({out_valid, in_sync, drop_count, out_x} !== 18'd0)
            $display("FAIL mid_reset: got valid=%b sync=%b drop=%0d x=%0d need 0", out_valid, in_sync, drop_count, out_x);
        else passed++;
        repeat (3) tick;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL mid_reset_lost: got valid=%b need 0", out_valid);
        else passed++;
        pulse_vsync;
        send_line(LW, 1'b0);
        tick;
        collect_line(8'd0, 1'b0);
    endtask

    // Continuous capture with the last pixel on the hsync cycle; exercises the
    // reader freeing a bank in the same cycle the writer needs it.
    task automatic test_back_to_back;
        do_reset;
        out_ready = 1'b1;
        pulse_vsync;
        fork
            begin
                send_line(LW, 1'b1);
                send_line(LW, 1'b1);
                send_line(LW, 1'b1);
            end
            begin
                collect_line(8'd0, 1'b0);
                collect_line(8'd1, 1'b0);
                collect_line(8'd2, 1'b0);
            end
        join
        checks++;
        if (drop_count !== 8'd0) $display("FAIL b2b_drop: got %0d need 0", drop_count);
        else passed++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single_line;
        test_backpressure;
        test_overflow;
        test_bad_lengths;
        test_no_vsync;
        test_reset_mid_stream;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
